dco_tune_ramp: RTL and testbench

- Control stage directly upstream of the 5x5 DCO row/column coder.
- Accepts a tuning target with an integer part and a fractional part.
- Clamps the integer part to the array range and slews the 5-bit coder word toward the target at a bounded rate.
- Once settled, applies first-order dithering of the fractional bits, so the average DCO code resolves below one LSB.

---
 rtl/dco_tune_ramp.sv | 149 ++++++++++++++
 tb/tb_dco_tune_ramp.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dco_tune_ramp.sv
// Tuning-word ramp and fractional dither ahead of the 5x5 DCO row/column coder.
// Slews the coder word toward a clamped target, then dithers the fraction once settled.
module dco_tune_ramp #(
    parameter int MAX      = 25,
    parameter int FRAC_W   = 4,
    parameter int STEP     = 1,
    parameter int RST_WORD = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load,
    input  logic [4:0]        tw_int,
    input  logic [FRAC_W-1:0] tw_frac,
    input  logic              dither_en,
    output logic [4:0]        word,
    output logic              word_en,
    output logic              busy,
    output logic              settled,
    output logic              sat
);

    typedef enum logic [1:0] {
        IDLE,
        RAMP,
        TRACK
    } state_t;

    localparam logic [4:0] MAX_W  = 5'(MAX);
    localparam logic [4:0] RST_W  = 5'(RST_WORD);
    localparam logic [4:0] STEP_W = 5'(STEP);

    state_t            state_q, state_d;
    logic [4:0]        word_q, word_d;
    logic [4:0]        tgt_int_q, tgt_int_d;
    logic [FRAC_W-1:0] tgt_frac_q, tgt_frac_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic              sat_q, sat_d;
    logic              pend_q, pend_d;
    logic              word_en_q;

    logic              clamp;
    logic              retarget;
    logic signed [5:0] diff;
    logic [4:0]        mag;
    logic [4:0]        stp;
    logic [4:0]        ramp_word;
    logic [FRAC_W:0]   sum;
    logic              carry;
    logic [4:0]        dith_word;

    // A load taken while en is low is remembered so the FSM acts on it later
    always_comb begin
        clamp      = tw_int > MAX_W;
        tgt_int_d  = tgt_int_q;
        tgt_frac_d = tgt_frac_q;
        sat_d      = sat_q;
        if (load) begin
            tgt_int_d  = clamp ? MAX_W : tw_int;
            tgt_frac_d = clamp ? '0 : tw_frac;
            sat_d      = clamp;
        end
        retarget = load | pend_q;
        pend_d   = en ? 1'b0 : retarget;
    end

    always_comb begin
        diff = $signed({1'b0, tgt_int_d}) - $signed({1'b0, word_q});
        mag  = diff[5] ? 5'(-diff) : diff[4:0];
        stp  = (mag < STEP_W) ? mag : STEP_W;
        ramp_word = diff[5] ? (word_q - stp) : (word_q + stp);
    end

    // Carry out of the fraction accumulator bumps the word by one LSB
    always_comb begin
        sum   = {1'b0, acc_q} + {1'b0, tgt_frac_d};
        carry = sum[FRAC_W];
        dith_word = (tgt_int_d == MAX_W) ? MAX_W
                                         : tgt_int_d + {4'b0, carry};
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        acc_d   = acc_q;
        if (en) begin
            unique case (state_q)
                IDLE: begin
                    if (retarget) begin
                        if (word_q != tgt_int_d) begin
                            state_d = RAMP;
                        end else begin
                            state_d = TRACK;
                            acc_d   = '0;
                        end
                    end
                end
                RAMP: begin
                    word_d = ramp_word;
                    if (ramp_word == tgt_int_d) begin
                        state_d = TRACK;
                        acc_d   = '0;
                    end
                end
                TRACK: begin
                    if (retarget && (word_q != tgt_int_d)) begin
                        state_d = RAMP;
                    end else if (dither_en && (tgt_frac_d != '0)) begin
                        acc_d  = sum[FRAC_W-1:0];
                        word_d = dith_word;
                    end else begin
                        acc_d  = '0;
                        word_d = tgt_int_d;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            word_q     <= RST_W;
            tgt_int_q  <= RST_W;
            tgt_frac_q <= '0;
            acc_q      <= '0;
            sat_q      <= 1'b0;
            pend_q     <= 1'b0;
            word_en_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            tgt_int_q  <= tgt_int_d;
            tgt_frac_q <= tgt_frac_d;
            acc_q      <= acc_d;
            sat_q      <= sat_d;
            pend_q     <= pend_d;
            word_en_q  <= en;
        end
    end

    assign word    = word_q;
    assign word_en = word_en_q;
    assign busy    = (state_q == RAMP);
    assign settled = (state_q == TRACK);
    assign sat     = sat_q;

endmodule

// File: tb/tb_dco_tune_ramp.sv
// Directed bench for dco_tune_ramp: ramp, clamp, dither, retarget, en stall, async reset.
// A second instance with STEP=4 covers the coarse-step ramp and dither at MAX.
module tb_dco_tune_ramp;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       load;
    logic [4:0] tw_int;
    logic [3:0] tw_frac;
    logic       dither_en;

    logic [4:0] word, word4;
    logic       word_en, word_en4;
    logic       busy, busy4;
    logic       settled, settled4;
    logic       sat, sat4;

    int checks   = 0;
    int failures = 0;
    int wsum;

    typedef struct packed {
        logic       ld;
        logic [4:0] ti;
        logic [3:0] tf;
        logic       e;
        logic       de;
        logic [4:0] w;
        logic       b;
        logic       s;
        logic       st;
    } vec_t;

    vec_t tbl [16];

    dco_tune_ramp #(.STEP(1)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load),
        .tw_int(tw_int), .tw_frac(tw_frac), .dither_en(dither_en),
        .word(word), .word_en(word_en), .busy(busy),
        .settled(settled), .sat(sat)
    );

    dco_tune_ramp #(.STEP(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .load(load),
        .tw_int(tw_int), .tw_frac(tw_frac), .dither_en(dither_en),
        .word(word4), .word_en(word_en4), .busy(busy4),
        .settled(settled4), .sat(sat4)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic chk4(input string nm, input int w, input int b,
                        input int s, input int st);
        chk({nm, ".word"}, int'(word), w);
        chk({nm, ".busy"}, int'(busy), b);
        chk({nm, ".settled"}, int'(settled), s);
        chk({nm, ".sat"}, int'(sat), st);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; load = 1'b0;
        tw_int = '0; tw_frac = '0; dither_en = 1'b0;
        #2;
        chk4("reset", 12, 0, 0, 0);
        chk("reset.word_en", int'(word_en), 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // ramp 12->20, then clamp load of 30 ramps to 25
        tbl[0]  = '{1'b1, 5'd20, 4'd0, 1'b1, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 5'd20, 4'd0, 1'b1, 1'b0, 5'd13, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 5'd20, 4'd0, 1'b1, 1'b0, 5'd14, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 5'd20, 4'd0, 1'b1, 1'b0, 5'd15, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 5'd20, 4'd0, 1'b1, 1'b0, 5'd16, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 5'd20, 4'd0, 1'b1, 1'b0, 5'd17, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 5'd20, 4'd0, 1'b1, 1'b0, 5'd18, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 5'd20, 4'd0, 1'b1, 1'b0, 5'd19, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 5'd20, 4'd0, 1'b1, 1'b0, 5'd20, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 5'd20, 4'd0, 1'b1, 1'b0, 5'd20, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 5'd30, 4'd7, 1'b1, 1'b0, 5'd20, 1'b1, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 5'd30, 4'd7, 1'b1, 1'b0, 5'd21, 1'b1, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 5'd30, 4'd7, 1'b1, 1'b0, 5'd22, 1'b1, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 5'd30, 4'd7, 1'b1, 1'b0, 5'd23, 1'b1, 1'b0, 1'b1};
        tbl[14] = '{1'b0, 5'd30, 4'd7, 1'b1, 1'b0, 5'd24, 1'b1, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 5'd30, 4'd7, 1'b1, 1'b0, 5'd25, 1'b0, 1'b1, 1'b1};

        for (int i = 0; i < 16; i++) begin
            load = tbl[i].ld; tw_int = tbl[i].ti; tw_frac = tbl[i].tf;
            en = tbl[i].e; dither_en = tbl[i].de;
            tick();
            chk4($sformatf("vec%0d", i), int'(tbl[i].w), int'(tbl[i].b),
                 int'(tbl[i].s), int'(tbl[i].st));
            chk($sformatf("vec%0d.word_en", i), int'(word_en), 1);
        end

        // ramp down 25 -> 3, sat cleared by the new load
        load = 1'b1; tw_int = 5'd3; tw_frac = 4'd0;
        tick();
        load = 1'b0;
        chk4("down.load", 25, 1, 0, 0);
        for (int i = 1; i <= 22; i++) begin
            tick();
            chk($sformatf("down%0d.word", i), int'(word), 25 - i);
        end
        chk("down.end.settled", int'(settled), 1);
        chk("down.end.busy", int'(busy), 0);

        // ramp 3 -> 10 then dither fraction 4/16
        load = 1'b1; tw_int = 5'd10;
        tick();
        load = 1'b0;
        for (int i = 1; i <= 7; i++) tick();
        chk4("to10", 10, 0, 1, 0);
        dither_en = 1'b1;
        tick();
        chk("dith0.word", int'(word), 10);
        load = 1'b1; tw_int = 5'd10; tw_frac = 4'd4;
        wsum = 0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            load = 1'b0;
            wsum += int'(word);
            chk($sformatf("dith%0d.word", k), int'(word),
                (k % 4 == 0) ? 11 : 10);
        end
        chk("dith.sum16", wsum, 164);
        chk("dith.settled", int'(settled), 1);
        dither_en = 1'b0;
        tick();
        chk("dith.off.word", int'(word), 10);

        // mid-ramp retarget at 15 toward 5, then en stall
        load = 1'b1; tw_int = 5'd20;
        tick();
        load = 1'b0;
        for (int i = 1; i <= 5; i++) tick();
        chk4("mid.at15", 15, 1, 0, 0);
        load = 1'b1; tw_int = 5'd5;
        tick();
        load = 1'b0;
        chk4("retgt", 14, 1, 0, 0);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("stall%0d.word", i), int'(word), 14);
            chk($sformatf("stall%0d.busy", i), int'(busy), 1);
            chk($sformatf("stall%0d.word_en", i), int'(word_en), 0);
        end
        en = 1'b1;
        tick();
        chk("resume.word", int'(word), 13);
        chk("resume.word_en", int'(word_en), 1);

        // clamped retarget, then async reset at word 17
        load = 1'b1; tw_int = 5'd31;
        tick();
        load = 1'b0;
        chk4("clamp2", 14, 1, 0, 1);
        for (int i = 0; i < 3; i++) tick();
        chk4("pre_rst", 17, 1, 0, 1);
        #2;
        rst = 1'b1;
        #1;
        chk4("async_rst", 12, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        load = 1'b1; tw_int = 5'd12; tw_frac = 4'd0;
        tick();
        load = 1'b0;
        chk4("direct_track", 12, 0, 1, 0);

        // load while en low is acted on at the next enabled edge
        en = 1'b0; load = 1'b1; tw_int = 5'd14;
        tick();
        load = 1'b0;
        chk4("pend.hold", 12, 0, 1, 0);
        en = 1'b1;
        tick();
        chk4("pend.go", 12, 1, 0, 0);
        tick();
        tick();
        chk4("pend.done", 14, 0, 1, 0);

        // STEP=4 instance: 12,16,20,24,25 then dither pinned at MAX
        rst = 1'b1;
        #1;
        chk("s4.rst.word", int'(word4), 12);
        @(negedge clk);
        rst = 1'b0;
        load = 1'b1; tw_int = 5'd25; tw_frac = 4'd0; dither_en = 1'b0;
        tick();
        load = 1'b0;
        chk("s4.load.word", int'(word4), 12);
        chk("s4.load.busy", int'(busy4), 1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("s4.ramp%0d", i), int'(word4),
                (i == 4) ? 25 : 12 + 4 * i);
        end
        chk("s4.settled", int'(settled4), 1);
        chk("s4.sat", int'(sat4), 0);
        chk("s4.word_en", int'(word_en4), 1);
        load = 1'b1; tw_int = 5'd25; tw_frac = 4'd15; dither_en = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            load = 1'b0;
            chk($sformatf("s4.dmax%0d", k), int'(word4), 25);
        end
        chk("s4.dmax.settled", int'(settled4), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
